// File: rtl/acc_frame_calibrator_if.sv
// Byte-stream input, calibrated-sample output and status bundle of acc_frame_calibrator.
// slave = calibrator side, master = byte source / estimator side.
interface acc_frame_calibrator_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_end;
  logic        recal;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] acc_x;
  logic [15:0] acc_y;
  logic [15:0] acc_z;
  logic        calibrated;
  logic        overrun;
  logic [7:0]  frame_err_cnt;

  modport master (
    output byte_valid, byte_data, frame_end, recal, out_ready,
    input  out_valid, acc_x, acc_y, acc_z, calibrated, overrun, frame_err_cnt
  );

  modport slave (
    input  byte_valid, byte_data, frame_end, recal, out_ready,
    output out_valid, acc_x, acc_y, acc_z, calibrated, overrun, frame_err_cnt
  );
endinterface

// File: rtl/acc_frame_calibrator.sv
// Assembles big-endian XYZ frames, learns per-axis bias at start-up, outputs bias-removed samples.
// Latency: frame_end edge E -> out_valid after E+1; output held until accepted, later samples dropped (overrun).
module acc_frame_calibrator #(
  parameter int               BYTES_PER_FRAME = 6,
  parameter int               CAL_SHIFT       = 4,
  parameter logic signed [15:0] Z_REF         = 16'sd16384
) (
  input  logic                  clk,
  input  logic                  reset,
  acc_frame_calibrator_if.slave bus
);
  localparam int         AW     = 17 + CAL_SHIFT;
  localparam logic [2:0] NBYTES = 3'(BYTES_PER_FRAME);

  typedef enum logic {CALIB, RUN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d, cnt_inc;
  logic [5:0][7:0]       slot_q, slot_d;
  logic [7:0]            err_q, err_d;
  logic [CAL_SHIFT-1:0]  cal_cnt_q, cal_cnt_d;
  logic signed [AW-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d, sum_z_q, sum_z_d;
  logic signed [AW-1:0]  nsum_x, nsum_y, nsum_z;
  logic signed [15:0]    bias_x_q, bias_x_d, bias_y_q, bias_y_d, bias_z_q, bias_z_d;
  logic                  calibrated_q, calibrated_d;
  logic                  stage_vld_q, stage_vld_d;
  logic signed [15:0]    stage_x_q, stage_x_d, stage_y_q, stage_y_d, stage_z_q, stage_z_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [15:0]    out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic                  overrun_q, overrun_d;
  logic signed [15:0]    raw_x, raw_y, raw_z;
  logic signed [16:0]    z_off;
  logic                  good, bad;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7FFF;
    return v[15:0];
  endfunction

  always_comb begin
    slot_d  = slot_q;
    cnt_inc = byte_cnt_q;
    if (bus.byte_valid) begin
      if (byte_cnt_q < NBYTES) slot_d[byte_cnt_q] = bus.byte_data;
      if (byte_cnt_q != 3'd7)  cnt_inc = byte_cnt_q + 3'd1;
    end
    byte_cnt_d = bus.frame_end ? 3'd0 : cnt_inc;
    // A recal on the frame_end cycle discards the frame without scoring it as an error.
    good = bus.frame_end && !bus.recal && (cnt_inc == NBYTES);
    bad  = bus.frame_end && !bus.recal && (cnt_inc != NBYTES);

    raw_x  = {slot_d[0], slot_d[1]};
    raw_y  = {slot_d[2], slot_d[3]};
    raw_z  = {slot_d[4], slot_d[5]};
    z_off  = 17'(raw_z) - 17'(Z_REF);
    nsum_x = sum_x_q + AW'(raw_x);
    nsum_y = sum_y_q + AW'(raw_y);
    nsum_z = sum_z_q + AW'(z_off);

    err_d = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    state_d      = state_q;
    cal_cnt_d    = cal_cnt_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    sum_z_d      = sum_z_q;
    bias_x_d     = bias_x_q;
    bias_y_d     = bias_y_q;
    bias_z_d     = bias_z_q;
    calibrated_d = calibrated_q;
    stage_vld_d  = 1'b0;
    stage_x_d    = stage_x_q;
    stage_y_d    = stage_y_q;
    stage_z_d    = stage_z_q;
    out_valid_d  = out_valid_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_z_d      = out_z_q;
    overrun_d    = overrun_q;

    if (bus.recal) begin
      state_d      = CALIB;
      cal_cnt_d    = '0;
      sum_x_d      = '0;
      sum_y_d      = '0;
      sum_z_d      = '0;
      bias_x_d     = '0;
      bias_y_d     = '0;
      bias_z_d     = '0;
      calibrated_d = 1'b0;
      stage_x_d    = '0;
      stage_y_d    = '0;
      stage_z_d    = '0;
      out_valid_d  = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      // Stage register feeds the load stage one edge after the frame is accepted.
      if (stage_vld_q) begin
        if (out_valid_q && !bus.out_ready) begin
          overrun_d = 1'b1;
        end else begin
          out_x_d     = sat16(17'(stage_x_q) - 17'(bias_x_q));
          out_y_d     = sat16(17'(stage_y_q) - 17'(bias_y_q));
          out_z_d     = sat16(17'(stage_z_q) - 17'(bias_z_q));
          out_valid_d = 1'b1;
        end
      end

      case (state_q)
        CALIB: begin
          if (good) begin
            if (&cal_cnt_q) begin
              bias_x_d     = 16'(nsum_x >>> CAL_SHIFT);
              bias_y_d     = 16'(nsum_y >>> CAL_SHIFT);
              bias_z_d     = 16'(nsum_z >>> CAL_SHIFT);
              calibrated_d = 1'b1;
              sum_x_d      = '0;
              sum_y_d      = '0;
              sum_z_d      = '0;
              cal_cnt_d    = '0;
              state_d      = RUN;
            end else begin
              sum_x_d   = nsum_x;
              sum_y_d   = nsum_y;
              sum_z_d   = nsum_z;
              cal_cnt_d = cal_cnt_q + CAL_SHIFT'(1);
            end
          end
        end
        RUN: begin
          if (good) begin
            stage_vld_d = 1'b1;
            stage_x_d   = raw_x;
            stage_y_d   = raw_y;
            stage_z_d   = raw_z;
          end
        end
        default: state_d = CALIB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CALIB;
      byte_cnt_q   <= '0;
      slot_q       <= '0;
      err_q        <= '0;
      cal_cnt_q    <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      sum_z_q      <= '0;
      bias_x_q     <= '0;
      bias_y_q     <= '0;
      bias_z_q     <= '0;
      calibrated_q <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      stage_z_q    <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_z_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      slot_q       <= slot_d;
      err_q        <= err_d;
      cal_cnt_q    <= cal_cnt_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      sum_z_q      <= sum_z_d;
      bias_x_q     <= bias_x_d;
      bias_y_q     <= bias_y_d;
      bias_z_q     <= bias_z_d;
      calibrated_q <= calibrated_d;
      stage_vld_q  <= stage_vld_d;
      stage_x_q    <= stage_x_d;
      stage_y_q    <= stage_y_d;
      stage_z_q    <= stage_z_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_z_q      <= out_z_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.acc_x         = out_x_q;
  assign bus.acc_y         = out_y_q;
  assign bus.acc_z         = out_z_q;
  assign bus.calibrated    = calibrated_q;
  assign bus.overrun       = overrun_q;
  assign bus.frame_err_cnt = err_q;
endmodule

// File: tb/tb_acc_frame_calibrator.sv
// Directed bench for acc_frame_calibrator (CAL_SHIFT=2) with an output scoreboard.
module tb_acc_frame_calibrator;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

  logic clk;
  logic rst_n;
  acc_frame_calibrator_if bus ();

  acc_frame_calibrator #(.CAL_SHIFT(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int      compared;
  int      mism;
  int      bx, by, bz;
  int      exp_err;
  sample_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cal(input logic [15:0] raw, input int bias);
    int d;
    d = int'($signed(raw)) - bias;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic fe);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.frame_end  = fe;
    tick();
    bus.byte_valid = 1'b0;
    bus.frame_end  = 1'b0;
  endtask

  task automatic end_frame();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic merged);
    put_byte(x[15:8], 1'b0);
    put_byte(x[7:0],  1'b0);
    put_byte(y[15:8], 1'b0);
    put_byte(y[7:0],  1'b0);
    put_byte(z[15:8], 1'b0);
    put_byte(z[7:0],  merged);
    if (!merged) end_frame();
  endtask

  task automatic pulse_recal();
    bus.recal = 1'b1;
    tick();
    bus.recal = 1'b0;
    bx = 0; by = 0; bz = 0;
  endtask

  task automatic calib(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int sx, sy, sz;
    sx = 0; sy = 0; sz = 0;
    for (int i = 0; i < 4; i++) begin
      chk("cal_pending", 16'(bus.calibrated), 16'd0);
      send_frame(x, y, z, 1'b0);
      sx += int'($signed(x));
      sy += int'($signed(y));
      sz += int'($signed(z)) - 16384;
    end
    chk("cal_done", 16'(bus.calibrated), 16'd1);
    chk("cal_no_out", 16'(bus.out_valid), 16'd0);
    bx = sx >>> 2;
    by = sy >>> 2;
    bz = sz >>> 2;
  endtask

  task automatic run_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input logic merged);
    sample_t e;
    e.x = cal(x, bx);
    e.y = cal(y, by);
    e.z = cal(z, bz);
    sb.push_back(e);
    send_frame(x, y, z, merged);
  endtask

  always @(negedge clk) begin
    sample_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      compared++;
      assert (sb.size() != 0) else begin
        mism++;
        $error("FAIL sb_unexpected: observed output x=%h, expected no output", bus.acc_x);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_acc_x", bus.acc_x, e.x);
        chk("sb_acc_y", bus.acc_y, e.y);
        chk("sb_acc_z", bus.acc_z, e.z);
      end
    end
  end

  initial begin
    compared = 0; mism = 0;
    bx = 0; by = 0; bz = 0; exp_err = 0;
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.frame_end  = 1'b0;
    bus.recal      = 1'b0;
    bus.out_ready  = 1'b1;

    // 1: bytes during reset have no effect
    tick();
    put_byte(8'h12, 1'b0);
    put_byte(8'h34, 1'b1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_acc_x", bus.acc_x, 16'd0);
    chk("rst_acc_z", bus.acc_z, 16'd0);
    chk("rst_calibrated", 16'(bus.calibrated), 16'd0);
    chk("rst_overrun", 16'(bus.overrun), 16'd0);
    chk("rst_err", 16'(bus.frame_err_cnt), 16'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_calibrated", 16'(bus.calibrated), 16'd0);

    // 2: calibration then first RUN sample with latency check
    calib(16'h0010, 16'hFFF0, 16'h4010);
    run_frame(16'h0020, 16'h0000, 16'h4000, 1'b0);
    @(negedge clk);
    chk("lat_e0_valid", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    chk("lat_e1_valid", 16'(bus.out_valid), 16'd1);
    chk("t2_acc_x", bus.acc_x, 16'd16);
    chk("t2_acc_y", bus.acc_y, 16'd16);
    chk("t2_acc_z", bus.acc_z, 16'h3FF0);
    @(negedge clk);
    chk("t2_valid_clear", 16'(bus.out_valid), 16'd0);

    // 3: saturation both ways
    tick();
    pulse_recal();
    chk("recal_uncal", 16'(bus.calibrated), 16'd0);
    calib(16'hFFF0, 16'h0000, 16'h4000);
    run_frame(16'h7FFF, 16'h0000, 16'h4000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sat_pos", bus.acc_x, 16'h7FFF);
    tick();
    pulse_recal();
    calib(16'h0010, 16'h0000, 16'h4000);
    run_frame(16'h8000, 16'h0000, 16'h4000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sat_neg", bus.acc_x, 16'h8000);

    // 4: backpressure and overrun
    tick();
    bus.out_ready = 1'b0;
    run_frame(16'h0110, 16'h1234, 16'h4000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", 16'(bus.out_valid), 16'd1);
    chk("bp_acc_x", bus.acc_x, 16'h0100);
    send_frame(16'h0555, 16'h0666, 16'h0777, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_overrun", 16'(bus.overrun), 16'd1);
    chk("bp_hold_valid", 16'(bus.out_valid), 16'd1);
    chk("bp_hold_x", bus.acc_x, 16'h0100);
    chk("bp_hold_y", bus.acc_y, 16'h1234);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_drained", 16'(bus.out_valid), 16'd0);
    tick();
    pulse_recal();
    chk("recal_overrun", 16'(bus.overrun), 16'd0);
    bus.out_ready = 1'b1;

    // 5: framing errors
    calib(16'h0000, 16'h0000, 16'h4000);
    for (int i = 0; i < 5; i++) put_byte(8'(i), 1'b0);
    end_frame();
    exp_err++;
    tick();
    tick();
    chk("short_err", 16'(bus.frame_err_cnt), 16'(exp_err));
    chk("short_no_out", 16'(bus.out_valid), 16'd0);
    for (int i = 0; i < 7; i++) put_byte(8'(i + 16), 1'b0);
    end_frame();
    exp_err++;
    tick();
    tick();
    chk("long_err", 16'(bus.frame_err_cnt), 16'(exp_err));
    run_frame(16'h1357, 16'hFEDC, 16'h4321, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("merged_valid", 16'(bus.out_valid), 16'd1);
    chk("merged_err", 16'(bus.frame_err_cnt), 16'(exp_err));

    // 6: recal on frame_end, then reset mid-frame
    tick();
    for (int i = 0; i < 6; i++) put_byte(8'(i + 32), 1'b0);
    bus.frame_end = 1'b1;
    bus.recal     = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    bus.recal     = 1'b0;
    bx = 0; by = 0; bz = 0;
    tick();
    tick();
    tick();
    chk("rc_no_out", 16'(bus.out_valid), 16'd0);
    chk("rc_uncal", 16'(bus.calibrated), 16'd0);
    chk("rc_err", 16'(bus.frame_err_cnt), 16'(exp_err));
    put_byte(8'hAA, 1'b0);
    put_byte(8'hBB, 1'b0);
    put_byte(8'hCC, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_err", 16'(bus.frame_err_cnt), 16'd0);
    exp_err = 0;
    tick();
    tick();
    rst_n = 1'b1;
    calib(16'h0100, 16'hFF00, 16'h4100);
    run_frame(16'h0200, 16'h0000, 16'h4000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_frame_x", bus.acc_x, 16'h0100);
    chk("rst_frame_y", bus.acc_y, 16'h0100);
    chk("rst_frame_z", bus.acc_z, 16'h3F00);
    chk("rst_frame_err", 16'(bus.frame_err_cnt), 16'(exp_err));
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
